alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, 1, number of cycles the shared ALU needs with alu_en high before alu_y/alu_c are valid (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  requester N (N = 0, 1) presents a command.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's command this cycle.
REQ-006 reqN_op  input  4  ALU function select (1 of 16), passed through untouched.
REQ-007 reqN_a, reqN_b  input  4 each  ALU operands.
REQ-008 rspN_valid  output  1  result for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes result.
REQ-010 rspN_data  output  4  ALU result; rspN_cout  output  1  ALU carry/borrow.
REQ-011 alu_en  output  1  enable to shared ALU (gates ALU outputs, as the unit's E input).
REQ-012 alu_op, alu_a, alu_b  output  4 each  command driven to shared ALU.
REQ-013 alu_y  input  4; alu_c  input  1  ALU result and carry out.

Function
REQ-014 FSM states IDLE, EXEC, RESP; one command in flight at a time.
REQ-015 IDLE: grant computed combinationally from reqN_valid; only the granted requester sees reqN_ready=1; the other sees 0.
REQ-016 Both valid: grant the requester not served last (round-robin pointer); one valid: grant it; none: both ready low.
REQ-017 Handshake: transfer when reqN_valid & reqN_ready; op/a/b/owner captured into registers; IDLE -> EXEC; pointer updated to owner.
REQ-018 EXEC: alu_en=1, alu_op/a/b = captured values, held stable for exactly ALU_LAT cycles; reqN_ready=0 for both.
REQ-019 Last EXEC cycle: alu_y/alu_c registered into rsp data; EXEC -> RESP.
REQ-020 Latency: accept at cycle T -> rspN_valid high from cycle T+ALU_LAT+1.
REQ-021 RESP: only the owner's rspN_valid=1; data/cout stable until rspN_ready; other rsp_valid=0.
REQ-022 RESP with owner rspN_ready=1: RESP -> IDLE; next accept no earlier than following cycle; min period ALU_LAT+2 cycles per op.
REQ-023 Outside EXEC: alu_en=0 and alu_op/a/b=0.
REQ-024 rspN_ready asserted while rspN_valid=0: ignored; requester dropping reqN_valid before transfer: no effect on state.
REQ-025 Owner not ready in RESP: arbiter stalls indefinitely; no new grants (no starvation of result).

Reset
REQ-026 rst high: state IDLE, pointer=1 (requester 0 wins first contention), all outputs 0 next edge.
REQ-027 Reset mid-EXEC or mid-RESP: command discarded, no response ever issued for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention, pointer logic removed; undefined: round-robin per REQ-016.

Structure
REQ-029 Shared package alu_pkg: 4-bit data/op width constant, FSM state encoding, ALU opcode constants used by benches.
REQ-030 Sub-module rr_arb2 (2-way round-robin grant with pointer); bypassed/tied when ALU_ARB_FIXED_PRIO_EN defined.

Verification
REQ-031 req0 op=dec, a=4'h5, ALU_LAT=1, bench ALU model -> req0_ready at T, alu_en high T+1 only, rsp0_valid T+2, rsp0_data=4'h4.
REQ-032 req0 and req1 valid together from reset, three ops each -> grant order 0,1,0,1,0,1; rsp to correct owner each time.
REQ-033 Same stimulus with ALU_ARB_FIXED_PRIO_EN -> all three req0 ops served before any req1.
REQ-034 rsp1_ready held low 10 cycles -> rsp1_valid/data stable 10 cycles, req0_ready stays 0, then IDLE one cycle after rsp1_ready.
REQ-035 ALU_LAT=3, a=4'h0 dec -> alu_en high exactly 3 cycles, rsp data 4'hF with borrow per ALU model.
REQ-036 rst pulsed during EXEC -> alu_en 0 next edge, no rsp_valid, next request served normally with req0 priority.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, FSM
// encoding, command bundle and ALU opcode constants used by benches.
package alu_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Opcodes understood by the shared ALU; the arbiter forwards them untouched.
  localparam logic [DATA_W-1:0] OP_ADD = 4'h0;
  localparam logic [DATA_W-1:0] OP_SUB = 4'h1;
  localparam logic [DATA_W-1:0] OP_INC = 4'h2;
  localparam logic [DATA_W-1:0] OP_DEC = 4'h3;
  localparam logic [DATA_W-1:0] OP_AND = 4'h4;
  localparam logic [DATA_W-1:0] OP_OR  = 4'h5;
  localparam logic [DATA_W-1:0] OP_XOR = 4'h6;

  typedef struct packed {
    logic [DATA_W-1:0] op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer remembers the requester served last;
// it resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= grant[1];
    end
  end

  // NOTE: grant gets a default before the case so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one multi-cycle ALU, one command in flight.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_cout,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_cout,
  output logic              alu_en,
  output logic [DATA_W-1:0] alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_c
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  logic [1:0]        state_q;
  alu_cmd_t          cmd_q;
  logic              owner_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] y_q;
  logic              c_q;

  logic [1:0] grant;
  logic       idle;
  logic       accept;
  logic       exec;
  logic       resp;
  logic       owner_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = req0_valid ? 2'b01 : (req1_valid ? 2'b10 : 2'b00);
`else
  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (grant)
  );
`endif

  // Ready is masked during reset so no command slips in on a reset edge.
  assign idle        = (state_q == ST_IDLE) && !rst;
  assign req0_ready  = idle & grant[0];
  assign req1_ready  = idle & grant[1];
  assign accept      = req0_ready | req1_ready;
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q   <= grant[1] ? alu_cmd_t'{req1_op, req1_a, req1_b}
                                : alu_cmd_t'{req0_op, req0_a, req0_b};
            owner_q <= grant[1];
            cnt_q   <= LAT_LAST;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            y_q     <= alu_y;
            c_q     <= alu_c;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (owner_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign exec   = (state_q == ST_EXEC);
  assign resp   = (state_q == ST_RESP);
  assign alu_en = exec;
  assign alu_op = exec ? cmd_q.op : '0;
  assign alu_a  = exec ? cmd_q.a  : '0;
  assign alu_b  = exec ? cmd_q.b  : '0;

  assign rsp0_valid = resp & ~owner_q;
  assign rsp1_valid = resp & owner_q;
  assign rsp0_data  = rsp0_valid ? y_q : '0;
  assign rsp0_cout  = rsp0_valid & c_q;
  assign rsp1_data  = rsp1_valid ? y_q : '0;
  assign rsp1_cout  = rsp1_valid & c_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one ALU_LAT=1 instance and one ALU_LAT=3
// instance, each with its own behavioural ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ALU_LAT = 1 instance
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_cout;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_cout;
  logic [3:0] req0_op, req0_a, req0_b, rsp0_data;
  logic [3:0] req1_op, req1_a, req1_b, rsp1_data;
  logic       alu_en, alu_c;
  logic [3:0] alu_op, alu_a, alu_b, alu_y;

  // ALU_LAT = 3 instance
  logic       l3_req0_valid, l3_req0_ready, l3_rsp0_valid, l3_rsp0_ready, l3_rsp0_cout;
  logic       l3_req1_valid, l3_req1_ready, l3_rsp1_valid, l3_rsp1_ready, l3_rsp1_cout;
  logic [3:0] l3_req0_op, l3_req0_a, l3_req0_b, l3_rsp0_data;
  logic [3:0] l3_req1_op, l3_req1_a, l3_req1_b, l3_rsp1_data;
  logic       l3_alu_en, l3_alu_c;
  logic [3:0] l3_alu_op, l3_alu_a, l3_alu_b, l3_alu_y;

  int vecs = 0;
  int errs = 0;

  // Behavioural ALU: {carry/borrow, result}, outputs forced low when disabled.
  function automatic logic [4:0] alu_model(input logic en, input logic [3:0] op,
                                           input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_INC:  r = {1'b0, a} + 5'd1;
      OP_DEC:  r = {1'b0, a} - 5'd1;
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = {1'b0, a};
    endcase
    return en ? r : 5'd0;
  endfunction

  assign {alu_c, alu_y}       = alu_model(alu_en, alu_op, alu_a, alu_b);
  assign {l3_alu_c, l3_alu_y} = alu_model(l3_alu_en, l3_alu_op, l3_alu_a, l3_alu_b);

  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_c(alu_c)
  );

  alu_arbiter #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_op(l3_req0_op),
    .req0_a(l3_req0_a), .req0_b(l3_req0_b), .rsp0_valid(l3_rsp0_valid),
    .rsp0_ready(l3_rsp0_ready), .rsp0_data(l3_rsp0_data), .rsp0_cout(l3_rsp0_cout),
    .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_op(l3_req1_op),
    .req1_a(l3_req1_a), .req1_b(l3_req1_b), .rsp1_valid(l3_rsp1_valid),
    .rsp1_ready(l3_rsp1_ready), .rsp1_data(l3_rsp1_data), .rsp1_cout(l3_rsp1_cout),
    .alu_en(l3_alu_en), .alu_op(l3_alu_op), .alu_a(l3_alu_a), .alu_b(l3_alu_b),
    .alu_y(l3_alu_y), .alu_c(l3_alu_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'h3; req0_b = 4'h4;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 4'h9; req1_b = 4'h1;
    tick;
    tick;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en} !== 5'b0) begin
      $display("FAIL reset_ctrl_in_rst: got %b exp 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en});
      errs++;
    end
    vecs++;
    if ({alu_op, alu_a, alu_b, rsp0_data, rsp1_data, rsp0_cout, rsp1_cout} !== 22'h0) begin
      $display("FAIL reset_data_in_rst: got %h exp 0",
               {alu_op, alu_a, alu_b, rsp0_data, rsp1_data, rsp0_cout, rsp1_cout});
      errs++;
    end
    vecs++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    #1;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en,
         l3_req0_ready, l3_rsp0_valid, l3_alu_en} !== 8'b0) begin
      $display("FAIL reset_idle: got %b exp 00000000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en,
                l3_req0_ready, l3_rsp0_valid, l3_alu_en});
      errs++;
    end
    vecs++;
  endtask

  // dec 5 with ALU_LAT=1: ready at T, alu_en at T+1 only, response at T+2.
  task automatic test_single;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_DEC; req0_a = 4'h5; req0_b = 4'h0;
    #1;
    if ({req0_ready, req1_ready, alu_en} !== 3'b100) begin
      $display("FAIL single_grant: got %b exp 100", {req0_ready, req1_ready, alu_en});
      errs++;
    end
    vecs++;
    tick;
    req0_valid = 1'b0;
    #1;
    if ({alu_en, alu_op, alu_a, req0_ready, rsp0_valid} !== {1'b1, OP_DEC, 4'h5, 2'b00}) begin
      $display("FAIL single_exec: got %b exp %b", {alu_en, alu_op, alu_a, req0_ready, rsp0_valid},
               {1'b1, OP_DEC, 4'h5, 2'b00});
      errs++;
    end
    vecs++;
    tick;
    if ({alu_en, alu_a, rsp0_valid, rsp1_valid, rsp0_data, rsp0_cout} !== {1'b0, 4'h0, 2'b10, 4'h4, 1'b0}) begin
      $display("FAIL single_resp: got %b exp %b", {alu_en, alu_a, rsp0_valid, rsp1_valid, rsp0_data, rsp0_cout},
               {1'b0, 4'h0, 2'b10, 4'h4, 1'b0});
      errs++;
    end
    vecs++;
    rsp0_ready = 1'b1;
    tick;
    rsp0_ready = 1'b0;
    if (rsp0_valid !== 1'b0) begin
      $display("FAIL single_release: got rsp0_valid=%b exp 0", rsp0_valid);
      errs++;
    end
    vecs++;
  endtask

  // Three ops per requester, both always pending; checks grant order and routing.
  task automatic test_round_robin;
    int order [6];
    logic [4:0] exp0 [3];
    logic [4:0] exp1 [3];
    int k0, k1, own;
    logic [11:0] exp_cmd;
    logic [4:0]  exp_rsp;
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 1, 1, 1};
`else
    order = '{0, 1, 0, 1, 0, 1};
`endif
    // req0: F + (k+1); req1: k - 1 (borrow on 0 - 1)
    exp0 = '{5'b1_0000, 5'b1_0001, 5'b1_0010};
    exp1 = '{5'b1_1111, 5'b0_0000, 5'b0_0001};
    k0 = 0;
    k1 = 0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      req0_valid = (k0 < 3); req0_op = OP_ADD; req0_a = 4'hF; req0_b = 4'(k0 + 1);
      req1_valid = (k1 < 3); req1_op = OP_SUB; req1_a = 4'(k1); req1_b = 4'h1;
      #1;
      own = order[t];
      if ({req1_ready, req0_ready} !== ((own == 1) ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_grant[%0d]: got {r1,r0}=%b exp owner %0d", t, {req1_ready, req0_ready}, own);
        errs++;
      end
      vecs++;
      exp_cmd = (own == 1) ? {OP_SUB, 4'(k1), 4'h1} : {OP_ADD, 4'hF, 4'(k0 + 1)};
      exp_rsp = (own == 1) ? exp1[k1] : exp0[k0];
      tick;
      if ({alu_en, alu_op, alu_a, alu_b, req0_ready, req1_ready} !== {1'b1, exp_cmd, 2'b00}) begin
        $display("FAIL rr_exec[%0d]: got %h exp %h", t, {alu_en, alu_op, alu_a, alu_b, req0_ready, req1_ready},
                 {1'b1, exp_cmd, 2'b00});
        errs++;
      end
      vecs++;
      tick;
      if (own == 1) begin
        if ({rsp1_valid, rsp0_valid, rsp1_cout, rsp1_data} !== {2'b10, exp_rsp}) begin
          $display("FAIL rr_rsp1[%0d]: got %b exp %b", t, {rsp1_valid, rsp0_valid, rsp1_cout, rsp1_data},
                   {2'b10, exp_rsp});
          errs++;
        end
        k1++;
      end else begin
        if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp0_data} !== {2'b10, exp_rsp}) begin
          $display("FAIL rr_rsp0[%0d]: got %b exp %b", t, {rsp0_valid, rsp1_valid, rsp0_cout, rsp0_data},
                   {2'b10, exp_rsp});
          errs++;
        end
        k0++;
      end
      vecs++;
      tick;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // req1 result held for 10 cycles while req0 waits; 7-2=5, then C&A=8.
  task automatic test_stall;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 4'h7; req1_b = 4'h2;
    #1;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      $display("FAIL stall_grant1: got %b exp 10", {req1_ready, req0_ready});
      errs++;
    end
    vecs++;
    tick;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 4'hC; req0_b = 4'hA;
    tick;
    for (int i = 0; i < 10; i++) begin
      if ({rsp1_valid, rsp0_valid, req0_ready, req1_ready, rsp1_data, rsp1_cout} !== {4'b1000, 4'h5, 1'b0}) begin
        $display("FAIL stall_hold[%0d]: got %b exp %b", i,
                 {rsp1_valid, rsp0_valid, req0_ready, req1_ready, rsp1_data, rsp1_cout}, {4'b1000, 4'h5, 1'b0});
        errs++;
      end
      vecs++;
      tick;
    end
    rsp1_ready = 1'b1;
    tick;
    rsp1_ready = 1'b0;
    if ({rsp1_valid, req0_ready} !== 2'b01) begin
      $display("FAIL stall_release: got {rsp1_valid,req0_ready}=%b exp 01", {rsp1_valid, req0_ready});
      errs++;
    end
    vecs++;
    tick;
    req0_valid = 1'b0;
    tick;
    if ({rsp0_valid, rsp0_data, rsp0_cout} !== {1'b1, 4'h8, 1'b0}) begin
      $display("FAIL stall_next_rsp0: got %b exp %b", {rsp0_valid, rsp0_data, rsp0_cout}, {1'b1, 4'h8, 1'b0});
      errs++;
    end
    vecs++;
    rsp0_ready = 1'b1;
    tick;
  endtask

  // ALU_LAT=3: dec 0 -> F with borrow, alu_en exactly 3 cycles, rsp at T+4.
  task automatic test_lat3;
    int en_cnt, lat;
    bit got;
    en_cnt = 0;
    lat = 0;
    got = 1'b0;
    l3_rsp0_ready = 1'b1;
    l3_req0_valid = 1'b1; l3_req0_op = OP_DEC; l3_req0_a = 4'h0; l3_req0_b = 4'h0;
    #1;
    if (l3_req0_ready !== 1'b1) begin
      $display("FAIL lat3_grant: got %b exp 1", l3_req0_ready);
      errs++;
    end
    vecs++;
    tick;
    l3_req0_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (l3_rsp0_valid === 1'b1) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (l3_alu_en === 1'b1) en_cnt++;
      tick;
    end
    if (!got) begin
      $display("FAIL lat3_timeout: got no rsp0_valid within 8 cycles exp at cycle 4");
      errs++;
    end
    vecs++;
    if (lat != 4 || en_cnt != 3) begin
      $display("FAIL lat3_timing: got latency %0d en_cycles %0d exp 4 and 3", lat, en_cnt);
      errs++;
    end
    vecs++;
    if ({l3_alu_en, l3_rsp0_data, l3_rsp0_cout} !== {1'b0, 4'hF, 1'b1}) begin
      $display("FAIL lat3_rsp: got %b exp %b", {l3_alu_en, l3_rsp0_data, l3_rsp0_cout}, {1'b0, 4'hF, 1'b1});
      errs++;
    end
    vecs++;
    tick;
  endtask

  // Reset while req1's XOR is executing: it vanishes, req0 is then served first.
  task automatic test_reset_exec;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 4'h3; req1_b = 4'h5;
    #1;
    if (req1_ready !== 1'b1) begin
      $display("FAIL rexec_grant1: got %b exp 1", req1_ready);
      errs++;
    end
    vecs++;
    tick;
    req1_valid = 1'b0;
    if (alu_en !== 1'b1) begin
      $display("FAIL rexec_in_exec: got alu_en=%b exp 1", alu_en);
      errs++;
    end
    vecs++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    if ({alu_en, alu_a, rsp0_valid, rsp1_valid} !== 7'b0) begin
      $display("FAIL rexec_after_rst: got %b exp 0", {alu_en, alu_a, rsp0_valid, rsp1_valid});
      errs++;
    end
    vecs++;
    for (int i = 0; i < 4; i++) begin
      tick;
      if ({rsp0_valid, rsp1_valid, alu_en} !== 3'b000) begin
        $display("FAIL rexec_no_rsp[%0d]: got %b exp 000", i, {rsp0_valid, rsp1_valid, alu_en});
        errs++;
      end
      vecs++;
    end
    req0_valid = 1'b1; req0_op = OP_OR; req0_a = 4'h1; req0_b = 4'h2;
    req1_valid = 1'b1;
    #1;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      $display("FAIL rexec_prio0: got %b exp 01", {req1_ready, req0_ready});
      errs++;
    end
    vecs++;
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, 4'h3}) begin
      $display("FAIL rexec_rsp0: got %b exp %b", {rsp0_valid, rsp1_valid, rsp0_data}, {2'b10, 4'h3});
      errs++;
    end
    vecs++;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;
    l3_req0_valid = 1'b0; l3_req0_op = '0; l3_req0_a = '0; l3_req0_b = '0; l3_rsp0_ready = 1'b0;
    l3_req1_valid = 1'b0; l3_req1_op = '0; l3_req1_a = '0; l3_req1_b = '0; l3_rsp1_ready = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_lat3;
    test_reset_exec;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
